// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg
// Shared definitions for the execute stage: bus widths, active-low enable
// levels, ALU / memory / control operation codes, exception codes and the
// state type of the optional multiplier.
package ex_stage_pkg;

    localparam int WORD_W     = 32;
    localparam int PC_W       = 30;
    localparam int REG_ADDR_W = 5;
    localparam int ALU_OP_W   = 4;
    localparam int MEM_OP_W   = 2;
    localparam int CTRL_OP_W  = 2;
    localparam int EXP_CODE_W = 3;

    // Valid and write-enable strobes are active-low throughout the pipeline
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam logic [ALU_OP_W-1:0] ALU_OP_NOP  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OP_XOR  = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_OP_ADDS = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_OP_ADDU = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUBS = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUBU = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SHRL = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SHLL = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_OP_MUL  = 4'd10;

    localparam logic [MEM_OP_W-1:0]  MEM_OP_NOP  = 2'd0;
    localparam logic [CTRL_OP_W-1:0] CTRL_OP_NOP = 2'd0;

    localparam logic [EXP_CODE_W-1:0] ISA_EXP_NO_EXP     = 3'd0;
    localparam logic [EXP_CODE_W-1:0] ISA_EXP_UNDEF_INSN = 3'd2;
    localparam logic [EXP_CODE_W-1:0] ISA_EXP_OVERFLOW   = 3'd3;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_BUSY,
        MUL_DONE
    } mul_state_t;

endpackage

// File: rtl/ex_alu.sv
// ex_alu
// Purely combinational ALU of the execute stage.
// Ports:
//   op        in   ALU operation code
//   in_0/in_1 in   operands
//   result    out  ALU result (0 for undefined operations and for MUL,
//                  whose product comes from the multiplier in ex_stage)
//   overflow  out  signed overflow of ADDS / SUBS
//   undef     out  operation code is unsupported in this configuration
// Parameter MUL_EN makes op 10 a legal operation (multiplier present).
module ex_alu
    import ex_stage_pkg::*;
#(
    parameter bit MUL_EN = 1'b0
) (
    input  logic [ALU_OP_W-1:0] op,
    input  logic [WORD_W-1:0]   in_0,
    input  logic [WORD_W-1:0]   in_1,
    output logic [WORD_W-1:0]   result,
    output logic                overflow,
    output logic                undef
);

    logic [WORD_W-1:0] sum;
    logic [WORD_W-1:0] diff;

    assign sum  = in_0 + in_1;
    assign diff = in_0 - in_1;

    // Operation select; overflow is judged from operand and result sign bits
    always_comb begin
        result   = '0;
        overflow = 1'b0;
        undef    = 1'b0;
        case (op)
            ALU_OP_NOP:  result = in_0;
            ALU_OP_AND:  result = in_0 & in_1;
            ALU_OP_OR:   result = in_0 | in_1;
            ALU_OP_XOR:  result = in_0 ^ in_1;
            ALU_OP_ADDS: begin
                result   = sum;
                overflow = (in_0[WORD_W-1] == in_1[WORD_W-1]) &&
                           (sum[WORD_W-1] != in_0[WORD_W-1]);
            end
            ALU_OP_ADDU: result = sum;
            ALU_OP_SUBS: begin
                result   = diff;
                overflow = (in_0[WORD_W-1] != in_1[WORD_W-1]) &&
                           (diff[WORD_W-1] != in_0[WORD_W-1]);
            end
            ALU_OP_SUBU: result = diff;
            ALU_OP_SHRL: result = in_0 >> in_1[4:0];
            ALU_OP_SHLL: result = in_0 << in_1[4:0];
            ALU_OP_MUL:  undef  = !MUL_EN;
            default:     undef  = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage
// Execute stage of the 5-stage pipeline. Computes the ALU result from the
// ID/EX register (id_*), merges exceptions, and latches the EX/MEM register
// (ex_*). fwd_data is the combinational result fed back for forwarding.
// Ports:
//   clk, reset          clock (rising edge), synchronous active-high reset
//   id_*                ID/EX register outputs (id_en_, id_gpr_we_ active-low)
//   stall, flush        hold the EX/MEM register / insert a bubble
//   fwd_data            current result (multiplier product while in DONE)
//   ex_*                registered copies of id_*, ex_out = registered result
//   busy                multi-cycle multiply in progress (0 without EX_MUL_EN)
// Optional feature: define EX_MUL_EN to implement op 10 (MUL) as a
// shift-add multiplier taking MUL_CYCLES iterations.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int MUL_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PC_W-1:0]       id_pc,
    input  logic                  id_en_,
    input  logic [ALU_OP_W-1:0]   id_alu_op,
    input  logic [WORD_W-1:0]     id_alu_in_0,
    input  logic [WORD_W-1:0]     id_alu_in_1,
    input  logic                  id_br_flag,
    input  logic [MEM_OP_W-1:0]   id_mem_op,
    input  logic [WORD_W-1:0]     id_mem_wr_data,
    input  logic [CTRL_OP_W-1:0]  id_ctrl_op,
    input  logic [REG_ADDR_W-1:0] id_dst_addr,
    input  logic                  id_gpr_we_,
    input  logic [EXP_CODE_W-1:0] id_exp_code,
    input  logic                  stall,
    input  logic                  flush,
    output logic [WORD_W-1:0]     fwd_data,
    output logic [PC_W-1:0]       ex_pc,
    output logic                  ex_en_,
    output logic                  ex_br_flag,
    output logic [MEM_OP_W-1:0]   ex_mem_op,
    output logic [WORD_W-1:0]     ex_mem_wr_data,
    output logic [CTRL_OP_W-1:0]  ex_ctrl_op,
    output logic [REG_ADDR_W-1:0] ex_dst_addr,
    output logic                  ex_gpr_we_,
    output logic [EXP_CODE_W-1:0] ex_exp_code,
    output logic [WORD_W-1:0]     ex_out,
    output logic                  busy
);

`ifdef EX_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    // Legal range of MUL_CYCLES is 1..32; this block only exists to name an
    // illegal setting in the elaborated hierarchy.
    if (MUL_CYCLES < 1 || MUL_CYCLES > 32) begin : g_mul_cycles_out_of_range
    end

    logic [WORD_W-1:0]     alu_result;
    logic                  alu_overflow;
    logic                  alu_undef;
    logic [WORD_W-1:0]     stage_result;
    logic [EXP_CODE_W-1:0] ld_exp_code;
    logic [MEM_OP_W-1:0]   ld_mem_op;
    logic                  ld_gpr_we_;

    ex_alu #(
        .MUL_EN (MUL_EN)
    ) u_alu (
        .op       (id_alu_op),
        .in_0     (id_alu_in_0),
        .in_1     (id_alu_in_1),
        .result   (alu_result),
        .overflow (alu_overflow),
        .undef    (alu_undef)
    );

`ifdef EX_MUL_EN
    // Each iteration consumes enough multiplier bits to cover 32 bits in
    // MUL_CYCLES iterations.
    localparam int BITS_PER_ITER = (WORD_W + MUL_CYCLES - 1) / MUL_CYCLES;

    mul_state_t        mul_state;
    logic [5:0]        mul_count;
    logic [WORD_W-1:0] mul_acc;
    logic [WORD_W-1:0] mul_mcand;
    logic [WORD_W-1:0] mul_mplier;
    logic [WORD_W-1:0] acc_next;
    logic [WORD_W-1:0] mcand_next;
    logic [WORD_W-1:0] mplier_next;
    logic              mul_valid;

    assign mul_valid    = (id_en_ == ENABLE_) && (id_alu_op == ALU_OP_MUL);
    assign busy         = ((mul_state == MUL_IDLE) && mul_valid) ||
                          (mul_state == MUL_BUSY);
    assign stage_result = (mul_state == MUL_DONE) ? mul_acc : alu_result;

    // One shift-add iteration: add the multiplicand for every set multiplier
    // bit, shifting the multiplicand up and the multiplier down each bit.
    always_comb begin
        acc_next    = mul_acc;
        mcand_next  = mul_mcand;
        mplier_next = mul_mplier;
        for (int i = 0; i < BITS_PER_ITER; i++) begin
            if (mplier_next[0]) begin
                acc_next = acc_next + mcand_next;
            end
            mcand_next  = mcand_next << 1;
            mplier_next = mplier_next >> 1;
        end
    end

    // Multiplier FSM. BUSY keeps iterating even while stall is high, since
    // upstream stalls on busy; flush abandons the product.
    always_ff @(posedge clk) begin
        if (reset) begin
            mul_state  <= MUL_IDLE;
            mul_count  <= '0;
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
        end else begin
            case (mul_state)
                MUL_IDLE: begin
                    if (mul_valid && !stall && !flush) begin
                        mul_acc    <= '0;
                        mul_mcand  <= id_alu_in_0;
                        mul_mplier <= id_alu_in_1;
                        mul_count  <= 6'(MUL_CYCLES - 1);
                        mul_state  <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    if (flush) begin
                        mul_state <= MUL_IDLE;
                    end else begin
                        mul_acc    <= acc_next;
                        mul_mcand  <= mcand_next;
                        mul_mplier <= mplier_next;
                        if (mul_count == '0) begin
                            mul_state <= MUL_DONE;
                        end else begin
                            mul_count <= mul_count - 6'd1;
                        end
                    end
                end
                MUL_DONE: begin
                    if (!stall) begin
                        mul_state <= MUL_IDLE;
                    end
                end
                default: mul_state <= MUL_IDLE;
            endcase
        end
    end
`else
    assign busy         = 1'b0;
    assign stage_result = alu_result;
`endif

    assign fwd_data = stage_result;

    // Exception merge: an incoming exception wins; otherwise a valid
    // instruction that overflows or is undefined raises its own exception
    // and is stripped of its memory access and register write.
    always_comb begin
        ld_exp_code = id_exp_code;
        ld_mem_op   = id_mem_op;
        ld_gpr_we_  = id_gpr_we_;
        if (id_en_ == ENABLE_ && id_exp_code == ISA_EXP_NO_EXP) begin
            if (alu_undef) begin
                ld_exp_code = ISA_EXP_UNDEF_INSN;
                ld_mem_op   = MEM_OP_NOP;
                ld_gpr_we_  = DISABLE_;
            end else if (alu_overflow) begin
                ld_exp_code = ISA_EXP_OVERFLOW;
                ld_mem_op   = MEM_OP_NOP;
                ld_gpr_we_  = DISABLE_;
            end
        end
    end

    // EX/MEM register: reset > stall > flush > load; an in-flight multiply
    // also holds the register.
    always_ff @(posedge clk) begin
        if (reset || (!stall && flush)) begin
            ex_pc          <= '0;
            ex_en_         <= DISABLE_;
            ex_br_flag     <= 1'b0;
            ex_mem_op      <= MEM_OP_NOP;
            ex_mem_wr_data <= '0;
            ex_ctrl_op     <= CTRL_OP_NOP;
            ex_dst_addr    <= '0;
            ex_gpr_we_     <= DISABLE_;
            ex_exp_code    <= ISA_EXP_NO_EXP;
            ex_out         <= '0;
        end else if (!stall && !busy) begin
            ex_pc          <= id_pc;
            ex_en_         <= id_en_;
            ex_br_flag     <= id_br_flag;
            ex_mem_op      <= ld_mem_op;
            ex_mem_wr_data <= id_mem_wr_data;
            ex_ctrl_op     <= id_ctrl_op;
            ex_dst_addr    <= id_dst_addr;
            ex_gpr_we_     <= ld_gpr_we_;
            ex_exp_code    <= ld_exp_code;
            ex_out         <= stage_result;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage
// Testbench for ex_stage: directed cases plus randomized traffic, checked
// every cycle against a behavioural model of the stage. Multiplier cases
// are included when EX_MUL_EN is defined.
module tb_ex_stage;

    localparam int MUL_CYCLES = 32;
`ifdef EX_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam longint MAX_S = 64'sd2147483647;
    localparam longint MIN_S = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] id_pc;
    logic        id_en_;
    logic [3:0]  id_alu_op;
    logic [31:0] id_alu_in_0;
    logic [31:0] id_alu_in_1;
    logic        id_br_flag;
    logic [1:0]  id_mem_op;
    logic [31:0] id_mem_wr_data;
    logic [1:0]  id_ctrl_op;
    logic [4:0]  id_dst_addr;
    logic        id_gpr_we_;
    logic [2:0]  id_exp_code;
    logic        stall;
    logic        flush;
    logic [31:0] fwd_data;
    logic [29:0] ex_pc;
    logic        ex_en_;
    logic        ex_br_flag;
    logic [1:0]  ex_mem_op;
    logic [31:0] ex_mem_wr_data;
    logic [1:0]  ex_ctrl_op;
    logic [4:0]  ex_dst_addr;
    logic        ex_gpr_we_;
    logic [2:0]  ex_exp_code;
    logic [31:0] ex_out;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: expected EX/MEM register contents
    bit          model_valid = 1'b0;
    logic [29:0] m_pc;
    logic        m_en_;
    logic        m_br;
    logic [1:0]  m_mem_op;
    logic [31:0] m_wr_data;
    logic [1:0]  m_ctrl;
    logic [4:0]  m_dst;
    logic        m_we_;
    logic [2:0]  m_exp;
    logic [31:0] m_out;
    // Cycles since a multiply was accepted: 0 idle, 1..MUL_CYCLES working,
    // MUL_CYCLES+1 product ready
    int          m_phase = 0;
    logic [31:0] m_prod = '0;

    ex_stage #(
        .MUL_CYCLES (MUL_CYCLES)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .id_pc          (id_pc),
        .id_en_         (id_en_),
        .id_alu_op      (id_alu_op),
        .id_alu_in_0    (id_alu_in_0),
        .id_alu_in_1    (id_alu_in_1),
        .id_br_flag     (id_br_flag),
        .id_mem_op      (id_mem_op),
        .id_mem_wr_data (id_mem_wr_data),
        .id_ctrl_op     (id_ctrl_op),
        .id_dst_addr    (id_dst_addr),
        .id_gpr_we_     (id_gpr_we_),
        .id_exp_code    (id_exp_code),
        .stall          (stall),
        .flush          (flush),
        .fwd_data       (fwd_data),
        .ex_pc          (ex_pc),
        .ex_en_         (ex_en_),
        .ex_br_flag     (ex_br_flag),
        .ex_mem_op      (ex_mem_op),
        .ex_mem_wr_data (ex_mem_wr_data),
        .ex_ctrl_op     (ex_ctrl_op),
        .ex_dst_addr    (ex_dst_addr),
        .ex_gpr_we_     (ex_gpr_we_),
        .ex_exp_code    (ex_exp_code),
        .ex_out         (ex_out),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Reference ALU from the arithmetic definitions; signed overflow is
    // detected by doing the math in 64 bits and checking the 32-bit range.
    function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r,
                                    output bit ovf, output bit undef);
        longint sa;
        longint sb;
        longint s;
        sa = $signed(a);
        sb = $signed(b);
        s = 0;
        r = '0;
        ovf = 1'b0;
        undef = 1'b0;
        case (op)
            4'd0: r = a;
            4'd1: r = a & b;
            4'd2: r = a | b;
            4'd3: r = a ^ b;
            4'd4: begin s = sa + sb; r = s[31:0]; ovf = (s > MAX_S) || (s < MIN_S); end
            4'd5: r = a + b;
            4'd6: begin s = sa - sb; r = s[31:0]; ovf = (s > MAX_S) || (s < MIN_S); end
            4'd7: r = a - b;
            4'd8: r = a >> b[4:0];
            4'd9: r = a << b[4:0];
            4'd10: undef = !MUL_EN;
            default: undef = 1'b1;
        endcase
    endfunction

    function automatic bit ref_busy();
        bit valid_mul;
        valid_mul = MUL_EN && (id_en_ == 1'b0) && (id_alu_op == 4'd10);
        return (m_phase == 0 && valid_mul) || (m_phase >= 1 && m_phase <= MUL_CYCLES);
    endfunction

    function automatic logic [31:0] ref_result();
        logic [31:0] r;
        bit ovf;
        bit und;
        ref_alu(id_alu_op, id_alu_in_0, id_alu_in_1, r, ovf, und);
        return (m_phase == MUL_CYCLES + 1) ? m_prod : r;
    endfunction

    task automatic clear_model();
        m_pc = '0; m_en_ = 1'b1; m_br = 1'b0; m_mem_op = '0; m_wr_data = '0;
        m_ctrl = '0; m_dst = '0; m_we_ = 1'b1; m_exp = '0; m_out = '0;
    endtask

    // Model update on every rising edge from the inputs in force
    always @(posedge clk) begin
        logic [31:0] r;
        bit ovf;
        bit und;
        bit busy_now;
        logic [31:0] res;
        int old_phase;
        ref_alu(id_alu_op, id_alu_in_0, id_alu_in_1, r, ovf, und);
        busy_now  = ref_busy();
        res       = ref_result();
        old_phase = m_phase;
        if (reset) begin
            clear_model();
            m_phase = 0;
            model_valid = 1'b1;
        end else begin
            if (stall) begin
            end else if (flush) begin
                clear_model();
            end else if (!busy_now) begin
                m_pc = id_pc; m_en_ = id_en_; m_br = id_br_flag; m_wr_data = id_mem_wr_data;
                m_ctrl = id_ctrl_op; m_dst = id_dst_addr; m_out = res;
                m_exp = id_exp_code; m_mem_op = id_mem_op; m_we_ = id_gpr_we_;
                if (!id_en_ && id_exp_code == 3'd0 && (und || ovf)) begin
                    m_exp = und ? 3'd2 : 3'd3;
                    m_mem_op = 2'd0;
                    m_we_ = 1'b1;
                end
            end
            if (old_phase == 0) begin
                if (busy_now && !stall && !flush) begin
                    m_phase = 1;
                    m_prod = id_alu_in_0 * id_alu_in_1;
                end
            end else if (old_phase <= MUL_CYCLES) begin
                m_phase = flush ? 0 : old_phase + 1;
            end else if (!stall) begin
                m_phase = 0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("ex_pc", 32'(ex_pc), 32'(m_pc));
            checkOutput("ex_en_", 32'(ex_en_), 32'(m_en_));
            checkOutput("ex_br_flag", 32'(ex_br_flag), 32'(m_br));
            checkOutput("ex_mem_op", 32'(ex_mem_op), 32'(m_mem_op));
            checkOutput("ex_mem_wr_data", ex_mem_wr_data, m_wr_data);
            checkOutput("ex_ctrl_op", 32'(ex_ctrl_op), 32'(m_ctrl));
            checkOutput("ex_dst_addr", 32'(ex_dst_addr), 32'(m_dst));
            checkOutput("ex_gpr_we_", 32'(ex_gpr_we_), 32'(m_we_));
            checkOutput("ex_exp_code", 32'(ex_exp_code), 32'(m_exp));
            checkOutput("ex_out", ex_out, m_out);
            checkOutput("fwd_data", fwd_data, ref_result());
            checkOutput("busy", 32'(busy), 32'(ref_busy()));
        end
    end

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic en_, input logic [1:0] mem_op, input logic [4:0] dst,
                                 input logic we_, input logic [2:0] exp_code);
        id_alu_op      = op;
        id_alu_in_0    = a;
        id_alu_in_1    = b;
        id_en_         = en_;
        id_mem_op      = mem_op;
        id_dst_addr    = dst;
        id_gpr_we_     = we_;
        id_exp_code    = exp_code;
        id_pc          = 30'($urandom);
        id_br_flag     = 1'($urandom);
        id_ctrl_op     = 2'($urandom);
        id_mem_wr_data = $urandom;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [3:0] op;
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        applyStimulus(4'd0, '0, '0, 1'b1, 2'd0, 5'd0, 1'b1, 3'd0);
        step();
        checkOutput("reset ex_en_", 32'(ex_en_), 32'd1);
        checkOutput("reset ex_gpr_we_", 32'(ex_gpr_we_), 32'd1);
        checkOutput("reset ex_out", ex_out, 32'd0);
        checkOutput("reset ex_exp_code", 32'(ex_exp_code), 32'd0);
        reset = 1'b0;

        applyStimulus(4'd5, 32'hFFFF_FFFF, 32'd2, 1'b0, 2'd0, 5'd1, 1'b0, 3'd0);
        step();
        checkOutput("addu ex_out", ex_out, 32'h1);
        checkOutput("addu model", m_out, 32'h1);
        checkOutput("addu ex_exp_code", 32'(ex_exp_code), 32'd0);
        checkOutput("addu ex_gpr_we_", 32'(ex_gpr_we_), 32'd0);
        checkOutput("addu ex_dst_addr", 32'(ex_dst_addr), 32'd1);

        applyStimulus(4'd4, 32'h7FFF_FFFF, 32'd1, 1'b0, 2'd2, 5'd3, 1'b0, 3'd0);
        step();
        checkOutput("adds ovf ex_out", ex_out, 32'h8000_0000);
        checkOutput("adds ovf ex_exp_code", 32'(ex_exp_code), 32'd3);
        checkOutput("adds ovf model exp", 32'(m_exp), 32'd3);
        checkOutput("adds ovf ex_gpr_we_", 32'(ex_gpr_we_), 32'd1);
        checkOutput("adds ovf ex_mem_op", 32'(ex_mem_op), 32'd0);

        applyStimulus(4'd1, 32'hF0, 32'h3C, 1'b0, 2'd1, 5'd4, 1'b0, 3'd0);
        step();
        checkOutput("and ex_out", ex_out, 32'h30);
        stall = 1'b1;
        applyStimulus(4'd3, 32'h1, 32'h2, 1'b0, 2'd0, 5'd5, 1'b0, 3'd0);
        step();
        checkOutput("stall1 ex_out", ex_out, 32'h30);
        applyStimulus(4'd2, 32'h100, 32'h2, 1'b0, 2'd0, 5'd6, 1'b0, 3'd0);
        step();
        checkOutput("stall2 ex_out", ex_out, 32'h30);
        stall = 1'b0; flush = 1'b1;
        step();
        checkOutput("flush ex_en_", 32'(ex_en_), 32'd1);
        checkOutput("flush ex_out", ex_out, 32'd0);
        flush = 1'b0;

        applyStimulus(4'd4, 32'h7FFF_FFFF, 32'd1, 1'b0, 2'd2, 5'd7, 1'b0, 3'd2);
        step();
        checkOutput("exp precedence", 32'(ex_exp_code), 32'd2);

        applyStimulus(4'd6, 32'h8000_0000, 32'd1, 1'b0, 2'd0, 5'd8, 1'b0, 3'd0);
        step();
        checkOutput("subs ovf ex_exp_code", 32'(ex_exp_code), 32'd3);
        checkOutput("subs ovf ex_out", ex_out, 32'h7FFF_FFFF);

        applyStimulus(4'd12, 32'h55, 32'h66, 1'b0, 2'd1, 5'd9, 1'b0, 3'd0);
        step();
        checkOutput("undef ex_exp_code", 32'(ex_exp_code), 32'd2);
        checkOutput("undef ex_out", ex_out, 32'd0);

        applyStimulus(4'd4, 32'h7FFF_FFFF, 32'd1, 1'b1, 2'd0, 5'd10, 1'b0, 3'd0);
        step();
        checkOutput("bubble ex_en_", 32'(ex_en_), 32'd1);
        checkOutput("bubble ex_exp_code", 32'(ex_exp_code), 32'd0);

        applyStimulus(4'd8, 32'h8000_0000, 32'd35, 1'b0, 2'd0, 5'd11, 1'b0, 3'd0);
        step();
        checkOutput("shrl ex_out", ex_out, 32'h1000_0000);
        applyStimulus(4'd9, 32'h0000_0003, 32'd31, 1'b0, 2'd0, 5'd12, 1'b0, 3'd0);
        step();
        checkOutput("shll ex_out", ex_out, 32'h8000_0000);

        // Randomized traffic; MUL is kept to the directed section
        for (int i = 0; i < 400; i++) begin
            op = 4'($urandom_range(0, 15));
            if (MUL_EN && op == 4'd10) op = 4'd5;
            applyStimulus(op, pick_operand(), pick_operand(), 1'($urandom_range(0, 3) == 0),
                          2'($urandom), 5'($urandom), 1'($urandom),
                          ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0);
            stall = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 49) == 0);
            step();
        end
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        step();

`ifdef EX_MUL_EN
        applyStimulus(4'd10, 32'h1234, 32'h10, 1'b0, 2'd0, 5'd13, 1'b0, 3'd0);
        for (int c = 0; c <= 32; c++) begin
            checkOutput($sformatf("mul busy cycle %0d", c), 32'(busy), 32'd1);
            step();
        end
        checkOutput("mul busy cycle 33", 32'(busy), 32'd0);
        checkOutput("mul fwd_data done", fwd_data, 32'h12340);
        step();
        checkOutput("mul ex_out cycle 34", ex_out, 32'h12340);
        applyStimulus(4'd0, 32'h0, 32'h0, 1'b1, 2'd0, 5'd0, 1'b1, 3'd0);
        step();

        applyStimulus(4'd10, 32'h1234, 32'h10, 1'b0, 2'd0, 5'd14, 1'b0, 3'd0);
        for (int c = 0; c < 10; c++) step();
        flush = 1'b1;
        id_en_ = 1'b1;
        step();
        flush = 1'b0;
        checkOutput("mul abort busy", 32'(busy), 32'd0);
        checkOutput("mul abort ex_en_", 32'(ex_en_), 32'd1);
        step();
`endif

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
